sipo_load_ctrl: RTL
===================

# sipo_load_ctrl

Serial load controller that sits directly upstream of the SIPO shift register in the decoder datapath. It accepts parallel words over a valid/ready handshake and serializes them MSB-first into the SIPO's `clear`/`enable`/`in` inputs. When exactly `SIZE` bits have been shifted, it pulses `frame_done`, which tells downstream logic that the SIPO parallel output holds a complete frame.

## Interface
Parameters:
- `SIZE`, 256, bits per frame; equals the SIPO length. `SIZE % WORD_W == 0` is required; any other value is illegal.
- `WORD_W`, 8, width of each input word.
- `CNT_W`, `$clog2(SIZE+1)`, width of `bit_count`.

Ports:
- `clk` — input, 1, the single clock; all state updates on its rising edge.
- `rnot` — input, 1, synchronous active-low reset, sampled on the `clk` rising edge.
- `start` — input, 1, begins a frame; honoured only in IDLE.
- `word_in` — input, `WORD_W`, parallel data word.
- `word_valid` — input, 1, `word_in` is valid.
- `word_ready` — output, 1, controller can accept a word this cycle.
- `sipo_clear` — output, 1, drives SIPO `clear` (active high).
- `sipo_enable` — output, 1, drives SIPO `enable`.
- `sipo_in` — output, 1, drives SIPO serial `in`.
- `busy` — output, 1, high in every state except IDLE.
- `frame_done` — output, 1, one-cycle pulse when the frame is complete.
- `bit_count` — output, `CNT_W`, bits shifted in the current or last frame.

## Operation
- All outputs are registered or decoded purely from state registers. There is no combinational path from any input to any output.
- Reset (`rnot`=0 at an edge): state becomes IDLE. `word_ready`, `sipo_clear`, `sipo_enable`, `sipo_in`, `busy`, `frame_done` are 0, `bit_count` is 0, and the hold register is 0.
- Reset does not drive `sipo_clear`. The SIPO contents are left to the system reset.
- FSM states: IDLE, CLEAR, WAIT_WORD, SHIFT, DONE.
  - IDLE: all handshake and SIPO outputs are 0. `start`=1 moves to CLEAR. `word_valid` is ignored.
  - CLEAR: `sipo_clear`=1 for exactly one cycle. `bit_count` is cleared to 0. Next state is WAIT_WORD.
  - WAIT_WORD: `word_ready`=1. When `word_valid`&`word_ready`, `word_in` is captured into the hold register, the phase counter is set to 0, and the FSM moves to SHIFT. Otherwise it stays in WAIT_WORD.
  - SHIFT: `sipo_enable`=1 and `sipo_in`=hold[`WORD_W`-1]. Each cycle the hold register shifts left by one, `bit_count` increments and the phase counter increments. `word_ready`=0.
    - After `WORD_W` cycles, the FSM moves to DONE if `bit_count` has reached `SIZE`, otherwise back to WAIT_WORD.
  - DONE: `frame_done`=1 for one cycle, then IDLE. `start` sampled in DONE is ignored.
- `start` asserted in any state other than IDLE is ignored. `bit_count` holds its final value (`SIZE`) until the next CLEAR.
- Bit order: each word goes out MSB first, and words go out in acceptance order. After the frame, SIPO `out[SIZE-1]` holds the MSB of the first word, and `out[0]` holds the LSB of the last word.

## Timing
- Start of frame: `start` sampled at edge E0 → CLEAR is active during cycle E0..E1 → the SIPO clears at E1 → WAIT_WORD begins at E1.
- Word accepted at edge A: `sipo_enable` is high for cycles A..A+`WORD_W`. The SIPO captures one bit at each of edges A+1..A+`WORD_W`.
- WAIT_WORD re-entry: `word_ready` returns high in cycle A+`WORD_W`.
- Throughput: `WORD_W`+1 cycles per word with `word_valid` held high.
- Minimum frame length, from `start` edge to the `frame_done` cycle: 1 + (`SIZE`/`WORD_W`)·(`WORD_W`+1) + 1 cycles.
- Idle gaps on `word_valid` stall WAIT_WORD. During a stall `sipo_enable`=0, so the SIPO holds its contents.
- Reset mid-operation (any state): at the next edge everything returns to reset values. The partially loaded SIPO is abandoned and the next frame's CLEAR cleans it.

## Test plan
Directed scenarios use `SIZE`=16, `WORD_W`=8, with the SIPO instantiated at 16 bits.
- Reset: `rnot` held low for 2 cycles → all outputs 0, `word_ready`=0. `start` pulsed with `rnot`=0 → no state change.
- Single frame: `start`, then `word_valid` held with 0xA5 followed by 0x3C.
  - `sipo_clear` pulses once.
  - `sipo_in` sequence is 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0.
  - Final SIPO out[15:0] = 0xA53C, `bit_count`=16.
  - One `frame_done` pulse, 20 cycles after the `start` edge.
- Gapped input: same words with `word_valid` low for 5 cycles between them → no `sipo_enable` during the gap, same 0xA53C, `frame_done` 5 cycles later than in the single-frame case.
- Ignored inputs:
  - `word_valid`=1 with 0xFF in IDLE → `word_ready`=0, no shift.
  - `start` pulsed during SHIFT → no extra CLEAR, frame completes normally.
- Reset mid-SHIFT: `rnot`=0 after 3 bits → next cycle in IDLE, `sipo_enable`=0, `bit_count`=0. A new frame with 0x0F, 0xF0 → SIPO = 0x0FF0.
- Back-to-back frames: `start` in the first IDLE cycle after `frame_done`, words 0x12, 0x34 → `bit_count` restarts at 0, SIPO = 0x1234, second `frame_done` pulse.

Source files
------------

// File: rtl/sipo_load_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sipo_load_ctrl_if                                            |
// | Description : Word valid/ready handshake feeding the SIPO load controller. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
interface sipo_load_ctrl_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;

    modport master (
        output word_in,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_in,
        input  word_valid,
        output word_ready
    );
endinterface
`default_nettype wire

// File: rtl/sipo_load_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sipo_load_ctrl                                               |
// | Description : Serializes handshaked parallel words MSB-first into a SIPO   |
// |               and pulses frame_done once SIZE bits have been shifted.      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module sipo_load_ctrl #(
    parameter int SIZE   = 256,
    parameter int WORD_W = 8,
    parameter int CNT_W  = $clog2(SIZE + 1)
) (
    input  logic             clk,
    input  logic             rnot,
    input  logic             start,
    sipo_load_ctrl_if.slave  bus,
    output logic             sipo_clear,
    output logic             sipo_enable,
    output logic             sipo_in,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] bit_count
);

    localparam int c_ph_w = ($clog2(WORD_W) > 0) ? $clog2(WORD_W) : 1;

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_clear = 3'd1;
    localparam logic [2:0] c_st_wait  = 3'd2;
    localparam logic [2:0] c_st_shift = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [c_ph_w-1:0] c_last_phase = c_ph_w'(WORD_W - 1);
    localparam logic [CNT_W-1:0]  c_last_bit   = CNT_W'(SIZE - 1);

    logic [2:0]        r_state;
    logic [WORD_W-1:0] r_hold;
    logic [c_ph_w-1:0] r_phase;

    // The serial bit is the hold MSB, gated so it reads 0 whenever not shifting.
    assign sipo_in = sipo_enable & r_hold[WORD_W-1];

    always_ff @(posedge clk) begin
        if (!rnot) begin
            r_state        <= c_st_idle;
            r_hold         <= '0;
            r_phase        <= '0;
            bus.word_ready <= 1'b0;
            sipo_clear     <= 1'b0;
            sipo_enable    <= 1'b0;
            busy           <= 1'b0;
            frame_done     <= 1'b0;
            bit_count      <= '0;
        end else begin
            sipo_clear <= 1'b0;
            frame_done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_state    <= c_st_clear;
                        sipo_clear <= 1'b1;
                        busy       <= 1'b1;
                        bit_count  <= '0;
                    end
                end
                c_st_clear: begin
                    r_state        <= c_st_wait;
                    bus.word_ready <= 1'b1;
                end
                c_st_wait: begin
                    if (bus.word_valid && bus.word_ready) begin
                        r_state        <= c_st_shift;
                        r_hold         <= bus.word_in;
                        r_phase        <= '0;
                        bus.word_ready <= 1'b0;
                        sipo_enable    <= 1'b1;
                    end
                end
                c_st_shift: begin
                    r_hold    <= r_hold << 1;
                    r_phase   <= r_phase + c_ph_w'(1);
                    bit_count <= bit_count + CNT_W'(1);
                    if (r_phase == c_last_phase) begin
                        sipo_enable <= 1'b0;
                        // bit_count still holds the pre-increment value here.
                        if (bit_count == c_last_bit) begin
                            r_state    <= c_st_done;
                            frame_done <= 1'b1;
                        end else begin
                            r_state        <= c_st_wait;
                            bus.word_ready <= 1'b1;
                        end
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state        <= c_st_idle;
                    bus.word_ready <= 1'b0;
                    sipo_enable    <= 1'b0;
                    busy           <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
